// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end. Owns the fetch PC, keeps at most
// one instruction-memory read in flight, buffers returned words with their
// PCs in a small FIFO and hands them to decode over a valid/ready handshake.
// A redirect flushes the FIFO and marks any in-flight read as stale.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                       clock,
    input  logic                       reset,
    output logic                       im_req,
    output logic [63:0]                im_addr,
    input  logic                       im_valid,
    input  logic [31:0]                im_data,
    input  logic                       redirect,
    input  logic [63:0]                redirect_pc,
    input  logic                       dec_ready,
    output logic                       dec_valid,
    output logic [31:0]                dec_instr,
    output logic [63:0]                dec_pc,
    output logic [$clog2(DEPTH+1)-1:0] queue_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT      = 2'd1,
        ST_WAIT_DROP = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [63:0]   fetch_pc_q, fetch_pc_d;
    logic [63:0]   req_pc_q, req_pc_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   instr_mem_d [DEPTH];
    logic [63:0]   pc_mem_q    [DEPTH];
    logic [63:0]   pc_mem_d    [DEPTH];

    logic issue_s;
    logic push_s;
    logic pop_s;
    logic not_empty_s;

    // A slot is reserved at issue time: only one read in flight and the
    // queue must have room, so a returning word can always be pushed.
    assign not_empty_s = (count_q != {CW{1'b0}});
    assign issue_s     = (state_q == ST_IDLE) && !redirect && (count_q < DEPTH_C);
    assign push_s      = (state_q == ST_WAIT) && im_valid && !redirect;
    assign pop_s       = not_empty_s && dec_ready && !redirect;

    assign im_req      = issue_s && !reset;
    assign im_addr     = (state_q == ST_IDLE) ? fetch_pc_q : req_pc_q;
    assign dec_valid   = not_empty_s;
    assign dec_instr   = instr_mem_q[rd_ptr_q];
    assign dec_pc      = pc_mem_q[rd_ptr_q];
    assign queue_count = count_q;

    // Next-state: fetch FSM, PC sequencing, FIFO pointers/count and storage writes.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_pc_d    = req_pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        instr_mem_d = instr_mem_q;
        pc_mem_d    = pc_mem_q;

        case (state_q)
            ST_IDLE: begin
                if (issue_s) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 64'd4;
                    state_d    = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // A redirect without the response leaves the read in flight;
                // its data must be swallowed when it eventually arrives.
                if (redirect) begin
                    state_d = im_valid ? ST_IDLE : ST_WAIT_DROP;
                end else if (im_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT_DROP: begin
                if (im_valid) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_DROP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Redirect wins over push/pop; the new PC overrides any increment above.
        if (redirect) begin
            fetch_pc_d = redirect_pc;
            wr_ptr_d   = {PW{1'b0}};
            rd_ptr_d   = {PW{1'b0}};
            count_d    = {CW{1'b0}};
        end else begin
            if (push_s) begin
                instr_mem_d[wr_ptr_q] = im_data;
                pc_mem_d[wr_ptr_q]    = req_pc_q;
                wr_ptr_d              = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end

            if (push_s && !pop_s) begin
                count_d = count_q + CW'(1);
            end else if (pop_s && !push_s) begin
                count_d = count_q - CW'(1);
            end else begin
                count_d = count_q;
            end
        end
    end

    // State registers with asynchronous reset to the power-on fetch context.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= 64'h0;
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_mem_q[i] <= 32'h0;
                pc_mem_q[i]    <= 64'h0;
            end
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            instr_mem_q <= instr_mem_d;
            pc_mem_q    <= pc_mem_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus a randomized run of fetch_queue
// against a queue-based reference model, with a latency-programmable memory.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [63:0] RPC   = 64'h1000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        im_req;
    logic [63:0] im_addr;
    logic        im_valid = 1'b0;
    logic [31:0] im_data = 32'h0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        dec_ready = 1'b0;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [63:0] dec_pc;
    logic [2:0]  queue_count;

    int n_cmp = 0;
    int n_bad = 0;

    // memory environment controls
    int          mem_lat = 1;
    bit          mem_inject = 1'b0;
    logic [31:0] inject_data = 32'h0;
    bit          req_seen = 1'b0;
    logic [63:0] req_seen_addr = 64'h0;
    bit          mem_pend = 1'b0;
    logic [63:0] mem_addr = 64'h0;
    int          mem_cnt = 0;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clock       (clock),
        .reset       (reset),
        .im_req      (im_req),
        .im_addr     (im_addr),
        .im_valid    (im_valid),
        .im_data     (im_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dec_ready   (dec_ready),
        .dec_valid   (dec_valid),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc),
        .queue_count (queue_count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32];
    endfunction

    // memory: note the request seen at the edge
    always @(posedge clock) begin
        req_seen      = im_req;
        req_seen_addr = im_addr;
    end

    // memory: return data mem_lat cycles after the request, driven at negedge
    always @(negedge clock) begin
        im_valid = 1'b0;
        im_data  = 32'h0;
        if (req_seen) begin
            mem_pend = 1'b1;
            mem_addr = req_seen_addr;
            mem_cnt  = mem_lat;
        end
        if (mem_inject) begin
            im_valid = 1'b1;
            im_data  = inject_data;
        end else if (mem_pend) begin
            mem_cnt = mem_cnt - 1;
            if (mem_cnt == 0) begin
                im_valid = 1'b1;
                im_data  = mem_word(mem_addr);
                mem_pend = 1'b0;
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset      = 1'b1;
        redirect   = 1'b0;
        dec_ready  = 1'b0;
        mem_lat    = 1;
        mem_inject = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_cmp++; if (im_req !== 1'b0) begin n_bad++; $display("FAIL reset_im_req: got %0h want 0", im_req); end
        n_cmp++; if (im_addr !== RPC) begin n_bad++; $display("FAIL reset_im_addr: got %h want %h", im_addr, RPC); end
        n_cmp++; if (dec_valid !== 1'b0) begin n_bad++; $display("FAIL reset_dec_valid: got %0h want 0", dec_valid); end
        n_cmp++; if (dec_instr !== 32'h0) begin n_bad++; $display("FAIL reset_dec_instr: got %h want 0", dec_instr); end
        n_cmp++; if (dec_pc !== 64'h0) begin n_bad++; $display("FAIL reset_dec_pc: got %h want 0", dec_pc); end
        n_cmp++; if (queue_count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", queue_count); end
    endtask

    task automatic test_stream();
        int k;
        int last;
        logic [63:0] exp_pc;
        apply_reset();
        dec_ready = 1'b1;
        #1;
        n_cmp++; if (im_req !== 1'b1) begin n_bad++; $display("FAIL stream_first_req: got %0h want 1", im_req); end
        n_cmp++; if (im_addr !== RPC) begin n_bad++; $display("FAIL stream_first_addr: got %h want %h", im_addr, RPC); end
        k = 0;
        last = 0;
        for (int c = 0; c < 20 && k < 3; c++) begin
            if (c > 0) tick();
            if (dec_valid === 1'b1) begin
                exp_pc = RPC + 64'(4 * k);
                n_cmp++; if (dec_pc !== exp_pc) begin n_bad++; $display("FAIL stream_pc: got %h want %h", dec_pc, exp_pc); end
                n_cmp++; if (dec_instr !== mem_word(exp_pc)) begin n_bad++; $display("FAIL stream_instr: got %h want %h", dec_instr, mem_word(exp_pc)); end
                if (k == 0) begin
                    n_cmp++; if (c != 2) begin n_bad++; $display("FAIL stream_latency: got cycle %0d want 2", c); end
                end else begin
                    n_cmp++; if (c - last != 2) begin n_bad++; $display("FAIL stream_spacing: got %0d want 2", c - last); end
                end
                last = c;
                k++;
            end
        end
        n_cmp++; if (k != 3) begin n_bad++; $display("FAIL stream_count: got %0d want 3", k); end
    endtask

    task automatic test_backpressure();
        bit full;
        bit seen;
        logic [63:0] exp_pc;
        apply_reset();
        dec_ready = 1'b0;
        #1;
        full = 1'b0;
        for (int c = 0; c < 40 && !full; c++) begin
            if (queue_count === 3'd4) full = 1'b1;
            else tick();
        end
        n_cmp++; if (!full) begin n_bad++; $display("FAIL bp_fill: got count %0d want 4", queue_count); end
        for (int c = 0; c < 3; c++) begin
            n_cmp++; if (im_req !== 1'b0) begin n_bad++; $display("FAIL bp_req_held: got %0h want 0", im_req); end
            n_cmp++; if (queue_count !== 3'd4) begin n_bad++; $display("FAIL bp_count_held: got %0d want 4", queue_count); end
            tick();
        end
        dec_ready = 1'b1;
        #1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            exp_pc = RPC + 64'(4 * i);
            n_cmp++; if (dec_valid !== 1'b1 || dec_pc !== exp_pc) begin n_bad++; $display("FAIL bp_pop_pc: got v=%0h %h want v=1 %h", dec_valid, dec_pc, exp_pc); end
            n_cmp++; if (dec_instr !== mem_word(exp_pc)) begin n_bad++; $display("FAIL bp_pop_instr: got %h want %h", dec_instr, mem_word(exp_pc)); end
            if (im_req === 1'b1 && !seen) begin
                seen = 1'b1;
                n_cmp++; if (im_addr !== 64'h1010) begin n_bad++; $display("FAIL bp_resume_addr: got %h want 1010", im_addr); end
            end
        end
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL bp_resume: got no request want request at 1010"); end
        dec_ready = 1'b0;
    endtask

    task automatic test_redirect_wait();
        bit got;
        apply_reset();
        dec_ready = 1'b1;
        mem_lat   = 3;
        #1;
        n_cmp++; if (im_req !== 1'b1 || im_addr !== RPC) begin n_bad++; $display("FAIL rw_first_req: got %0h %h want 1 %h", im_req, im_addr, RPC); end
        tick();
        redirect    = 1'b1;
        redirect_pc = 64'h2000;
        #1;
        n_cmp++; if (im_req !== 1'b0) begin n_bad++; $display("FAIL rw_req_in_wait: got %0h want 0", im_req); end
        tick();
        redirect = 1'b0;
        #1;
        n_cmp++; if (im_req !== 1'b0) begin n_bad++; $display("FAIL rw_req_drop: got %0h want 0", im_req); end
        n_cmp++; if (queue_count !== 3'd0 || dec_valid !== 1'b0) begin n_bad++; $display("FAIL rw_empty: got %0d/%0h want 0/0", queue_count, dec_valid); end
        tick();
        n_cmp++; if (im_req !== 1'b0) begin n_bad++; $display("FAIL rw_req_stale: got %0h want 0", im_req); end
        tick();
        n_cmp++; if (im_req !== 1'b1 || im_addr !== 64'h2000) begin n_bad++; $display("FAIL rw_new_req: got %0h %h want 1 2000", im_req, im_addr); end
        n_cmp++; if (queue_count !== 3'd0) begin n_bad++; $display("FAIL rw_stale_pushed: got %0d want 0", queue_count); end
        got = 1'b0;
        for (int c = 0; c < 12 && !got; c++) begin
            tick();
            if (dec_valid === 1'b1) begin
                got = 1'b1;
                n_cmp++; if (dec_pc !== 64'h2000 || dec_instr !== mem_word(64'h2000)) begin n_bad++; $display("FAIL rw_first_pc: got %h %h want 2000 %h", dec_pc, dec_instr, mem_word(64'h2000)); end
            end
        end
        n_cmp++; if (!got) begin n_bad++; $display("FAIL rw_timeout: got no dec_valid want one"); end
    endtask

    task automatic test_redirect_full();
        bit found;
        bit got;
        apply_reset();
        dec_ready = 1'b0;
        mem_lat   = 3;
        #1;
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (queue_count === 3'd3 && im_valid === 1'b1) found = 1'b1;
            else tick();
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL rf_setup: got count %0d want 3 with response", queue_count); end
        redirect    = 1'b1;
        redirect_pc = 64'h3000;
        dec_ready   = 1'b1;
        #1;
        n_cmp++; if (dec_valid !== 1'b1) begin n_bad++; $display("FAIL rf_pop_offered: got %0h want 1", dec_valid); end
        tick();
        redirect  = 1'b0;
        dec_ready = 1'b0;
        #1;
        n_cmp++; if (queue_count !== 3'd0) begin n_bad++; $display("FAIL rf_count: got %0d want 0", queue_count); end
        n_cmp++; if (dec_valid !== 1'b0) begin n_bad++; $display("FAIL rf_dec_valid: got %0h want 0", dec_valid); end
        n_cmp++; if (im_req !== 1'b1 || im_addr !== 64'h3000) begin n_bad++; $display("FAIL rf_next_req: got %0h %h want 1 3000", im_req, im_addr); end
        dec_ready = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 15 && !got; c++) begin
            tick();
            if (dec_valid === 1'b1) begin
                got = 1'b1;
                n_cmp++; if (dec_pc !== 64'h3000) begin n_bad++; $display("FAIL rf_first_pc: got %h want 3000", dec_pc); end
            end
        end
        n_cmp++; if (!got) begin n_bad++; $display("FAIL rf_timeout: got no dec_valid want one"); end
    endtask

    task automatic test_wrap();
        bit got;
        apply_reset();
        dec_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        #1;
        n_cmp++; if (im_req !== 1'b0) begin n_bad++; $display("FAIL wrap_redirect_req: got %0h want 0", im_req); end
        tick();
        redirect = 1'b0;
        #1;
        n_cmp++; if (im_req !== 1'b1 || im_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_bad++; $display("FAIL wrap_top_req: got %0h %h want 1 fffffffffffffffc", im_req, im_addr); end
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            if (im_req === 1'b1) begin
                got = 1'b1;
                n_cmp++; if (im_addr !== 64'h0) begin n_bad++; $display("FAIL wrap_addr: got %h want 0", im_addr); end
                n_cmp++; if (dec_valid !== 1'b1 || dec_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin n_bad++; $display("FAIL wrap_dec_pc: got %0h %h want 1 fffffffffffffffc", dec_valid, dec_pc); end
                n_cmp++; if (dec_instr !== mem_word(64'hFFFF_FFFF_FFFF_FFFC)) begin n_bad++; $display("FAIL wrap_instr: got %h want %h", dec_instr, mem_word(64'hFFFF_FFFF_FFFF_FFFC)); end
            end
        end
        n_cmp++; if (!got) begin n_bad++; $display("FAIL wrap_timeout: got no request want one"); end
    endtask

    task automatic test_reset_mid();
        bit found;
        apply_reset();
        dec_ready = 1'b0;
        #1;
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            if (queue_count === 3'd2 && im_req === 1'b1) found = 1'b1;
            else tick();
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL rm_setup: got count %0d want 2", queue_count); end
        mem_lat = 50;
        tick();
        n_cmp++; if (queue_count !== 3'd2 || im_req !== 1'b0) begin n_bad++; $display("FAIL rm_wait: got %0d/%0h want 2/0", queue_count, im_req); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (im_req !== 1'b0) begin n_bad++; $display("FAIL rm_im_req: got %0h want 0", im_req); end
        n_cmp++; if (im_addr !== RPC) begin n_bad++; $display("FAIL rm_im_addr: got %h want %h", im_addr, RPC); end
        n_cmp++; if (dec_valid !== 1'b0) begin n_bad++; $display("FAIL rm_dec_valid: got %0h want 0", dec_valid); end
        n_cmp++; if (dec_instr !== 32'h0 || dec_pc !== 64'h0) begin n_bad++; $display("FAIL rm_dec_data: got %h %h want 0 0", dec_instr, dec_pc); end
        n_cmp++; if (queue_count !== 3'd0) begin n_bad++; $display("FAIL rm_count: got %0d want 0", queue_count); end
        mem_lat = 1;
        @(negedge clock);
        #1;
        inject_data = 32'hDEAD_BEEF;
        mem_inject  = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        mem_inject = 1'b0;
        n_cmp++; if (im_req !== 1'b1 || im_addr !== RPC) begin n_bad++; $display("FAIL rm_release_req: got %0h %h want 1 %h", im_req, im_addr, RPC); end
        tick();
        n_cmp++; if (queue_count !== 3'd0 || im_req !== 1'b0) begin n_bad++; $display("FAIL rm_stale_ignored: got %0d/%0h want 0/0", queue_count, im_req); end
        tick();
        tick();
        n_cmp++; if (dec_valid !== 1'b1 || dec_pc !== RPC || dec_instr !== mem_word(RPC)) begin n_bad++; $display("FAIL rm_first_fetch: got %0h %h %h want 1 %h %h", dec_valid, dec_pc, dec_instr, RPC, mem_word(RPC)); end
    endtask

    task automatic test_random();
        logic [63:0] mq[$];
        bit          out_req;
        bit          keep;
        bit          exp_req;
        logic [63:0] fpc;
        logic [63:0] mreq_pc;
        int          sz;
        int          ready_pct;
        apply_reset();
        out_req = 1'b0;
        keep    = 1'b0;
        fpc     = RPC;
        mreq_pc = 64'h0;
        ready_pct = 70;
        for (int cyc = 0; cyc < 900; cyc++) begin
            if (cyc % 150 == 0) ready_pct = (ready_pct == 70) ? 15 : 70;
            redirect  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0)
                redirect_pc = 64'hFFFF_FFFF_FFFF_FFF4;
            else
                redirect_pc = {$urandom, $urandom} & ~64'h3;
            dec_ready = ($urandom_range(0, 99) < ready_pct);
            mem_lat   = $urandom_range(1, 3);
            #1;
            sz = mq.size();
            exp_req = !out_req && !redirect && (sz < int'(DEPTH));
            n_cmp++; if (im_req !== exp_req) begin n_bad++; $display("FAIL rnd_im_req@%0d: got %0h want %0h", cyc, im_req, exp_req); end
            if (exp_req) begin
                n_cmp++; if (im_addr !== fpc) begin n_bad++; $display("FAIL rnd_im_addr@%0d: got %h want %h", cyc, im_addr, fpc); end
            end else if (out_req && keep) begin
                n_cmp++; if (im_addr !== mreq_pc) begin n_bad++; $display("FAIL rnd_hold_addr@%0d: got %h want %h", cyc, im_addr, mreq_pc); end
            end
            n_cmp++; if (queue_count !== 3'(sz)) begin n_bad++; $display("FAIL rnd_count@%0d: got %0d want %0d", cyc, queue_count, sz); end
            n_cmp++; if (dec_valid !== (sz != 0)) begin n_bad++; $display("FAIL rnd_dec_valid@%0d: got %0h want %0h", cyc, dec_valid, sz != 0); end
            if (sz != 0) begin
                n_cmp++; if (dec_pc !== mq[0]) begin n_bad++; $display("FAIL rnd_dec_pc@%0d: got %h want %h", cyc, dec_pc, mq[0]); end
                n_cmp++; if (dec_instr !== mem_word(mq[0])) begin n_bad++; $display("FAIL rnd_dec_instr@%0d: got %h want %h", cyc, dec_instr, mem_word(mq[0])); end
            end
            // reference model: effect of the coming clock edge
            if (dec_ready && sz != 0 && !redirect) void'(mq.pop_front());
            if (im_valid && out_req) begin
                if (keep && !redirect) mq.push_back(mreq_pc);
                out_req = 1'b0;
            end
            if (exp_req) begin
                out_req = 1'b1;
                keep    = 1'b1;
                mreq_pc = fpc;
                fpc     = fpc + 64'd4;
            end
            if (redirect) begin
                mq.delete();
                keep = 1'b0;
                fpc  = redirect_pc;
            end
            @(negedge clock);
        end
        redirect  = 1'b0;
        dec_ready = 1'b0;
    endtask

    // watchdog so the run always terminates
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_full();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
